// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions.
//   pcsrc_e         : next-PC source select driven by decode
//   MIPS_RESET_PC   : default fetch address after reset
//   MIPS_NOP_INSTR  : bubble instruction word (sll $0,$0,0)
package mips_pkg;

  typedef enum logic [1:0] {
    PCSRC_SEQ = 2'b00,  // PC+4
    PCSRC_BR  = 2'b01,  // branch target from ID
    PCSRC_J   = 2'b10,  // j/jal pseudo-direct
    PCSRC_JR  = 2'b11   // jr/jalr register target
  } pcsrc_e;

  localparam logic [31:0] MIPS_RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] MIPS_NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/if_next_pc.sv
// Next-PC selection for the fetch stage (purely combinational).
// Ports:
//   pc_i            current fetch PC
//   pcsrc_i         next-PC source (see mips_pkg::pcsrc_e)
//   br_target_i     branch target word address bits [31:2]
//   jump_index_i    instr_index field of j/jal
//   pc4_id_hi_i     PC_plus4_ID[31:28], region base for j/jal
//   jr_target_i     register target word address bits [31:2]
//   pc_plus4_o      pc_i + 4 (wraps modulo 2^32)
//   next_pc_o       selected next PC, always word aligned
module if_next_pc
  import mips_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [1:0]  pcsrc_i,
  input  logic [29:0] br_target_i,
  input  logic [25:0] jump_index_i,
  input  logic [3:0]  pc4_id_hi_i,
  input  logic [29:0] jr_target_i,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] next_pc_o
);

  logic [31:0] seq_pc;

  assign seq_pc     = pc_i + 32'd4;
  assign pc_plus4_o = seq_pc;

  // Low two bits are forced to zero on every path, including PC+4, so a
  // misaligned PC can never persist past one edge.
  always_comb begin
    next_pc_o = {seq_pc[31:2], 2'b00};
    case (pcsrc_e'(pcsrc_i))
      PCSRC_SEQ: next_pc_o = {seq_pc[31:2], 2'b00};
      PCSRC_BR:  next_pc_o = {br_target_i, 2'b00};
      PCSRC_J:   next_pc_o = {pc4_id_hi_i, jump_index_i, 2'b00};
      PCSRC_JR:  next_pc_o = {jr_target_i, 2'b00};
      default:   next_pc_o = {seq_pc[31:2], 2'b00};
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and IF/ID register.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   Keep_PC             hold PC (load-use stall)
//   Keep_IF_ID          hold IF/ID register (load-use stall)
//   Flush_IF_ID         replace IF/ID with a bubble (taken redirect in ID)
//   PCSrc               00 PC+4, 01 branch, 10 j/jal, 11 jr/jalr
//   BranchTarget        branch target from ID
//   JumpIndex           instr_index of j/jal in ID
//   JrTarget            forwarded rs for jr/jalr
//   imem_addr/imem_data combinational instruction memory read
//   PC_IF               current fetch PC
//   instr_ID, PC_plus4_ID, valid_ID   IF/ID register outputs
//   stall_cnt, flush_cnt              performance counters (PERF_CNT_EN only)
// Configuration macro: PERF_CNT_EN adds saturating stall/flush counters.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = MIPS_RESET_PC,
  parameter logic [31:0] NOP_INSTR = MIPS_NOP_INSTR,
  parameter int unsigned CNT_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Keep_PC,
  input  logic              Keep_IF_ID,
  input  logic              Flush_IF_ID,
  input  logic [1:0]        PCSrc,
  input  logic [31:0]       BranchTarget,
  input  logic [25:0]       JumpIndex,
  input  logic [31:0]       JrTarget,
  output logic [31:0]       imem_addr,
  input  logic [31:0]       imem_data,
  output logic [31:0]       PC_IF,
  output logic [31:0]       instr_ID,
  output logic [31:0]       PC_plus4_ID,
  output logic              valid_ID
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] pc4_q;
  logic        valid_q;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;

  if_next_pc u_next_pc (
    .pc_i         (pc_q),
    .pcsrc_i      (PCSrc),
    .br_target_i  (BranchTarget[31:2]),
    .jump_index_i (JumpIndex),
    .pc4_id_hi_i  (pc4_q[31:28]),
    .jr_target_i  (JrTarget[31:2]),
    .pc_plus4_o   (pc_plus4),
    .next_pc_o    (next_pc)
  );

  // PC: reset > hold > next. A redirect seen while held is dropped; decode
  // keeps presenting it because its instruction is held too.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (!Keep_PC) begin
      pc_q <= next_pc;
    end
  end

  // IF/ID: reset > hold > flush > load. Hold beats flush so a stalled
  // branch cannot kill its successor before the branch itself advances.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (!Keep_IF_ID) begin
      if (Flush_IF_ID) begin
        instr_q <= NOP_INSTR;
        pc4_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        instr_q <= imem_data;
        pc4_q   <= pc_plus4;
        valid_q <= 1'b1;
      end
    end
  end

  assign imem_addr   = pc_q;
  assign PC_IF       = pc_q;
  assign instr_ID    = instr_q;
  assign PC_plus4_ID = pc4_q;
  assign valid_ID    = valid_q;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (Keep_PC && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (Flush_IF_ID && !Keep_IF_ID && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  // CNT_W only sizes the counters; kept so the parameter list is identical
  // in both builds.
  if (CNT_W == 0) begin : g_no_counters
  end
`endif

endmodule
